// File: rtl/phase_deserializer.sv
// phase_deserializer: aligns fast-clock data beats to a slow-clock phase pulse,
// assembles MULT beats into one wide word and tracks lock on the pulse spacing.
// Optional feature: define PHASE_DESER_ERRCNT_EN to build the saturating error
// counter behind err_count_o; otherwise err_count_o is tied to zero.
module phase_deserializer #(
  parameter int unsigned MULT       = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       phase_i,
  input  logic [DATA_WIDTH-1:0]      dat_i,
  output logic [DATA_WIDTH*MULT-1:0] dat_o,
  output logic                       valid_o,
  output logic                       locked_o,
  output logic                       err_o,
  output logic [15:0]                err_count_o
);

  localparam int unsigned CntW = (MULT > 1) ? $clog2(MULT) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(MULT - 1);

  typedef enum logic [1:0] {StUnlocked, StLocking, StLocked} state_e;

  typedef logic [MULT-1:0][DATA_WIDTH-1:0] word_t;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      good_q, good_d;
  logic [8:0]      good_inc;
  word_t           asm_q, asm_d;
  word_t           dat_q, dat_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;

  logic            last_beat;
  logic            correct;
  logic            early;
  logic            missing;
  logic [CntW-1:0] idx;
  logic            fire;

  // Beat tracking and pulse classification against the free-running counter.
  always_comb begin
    last_beat = (cnt_q == LastIdx);
    correct   = phase_i & last_beat;
    early     = phase_i & ~last_beat;
    missing   = ~phase_i & last_beat;
    if (phase_i || last_beat) begin
      idx = '0;
    end else begin
      idx = cnt_q + CntW'(1);
    end
    cnt_d    = idx;
    good_inc = {1'b0, good_q} + 9'd1;
  end

  // State register plus datapath registers; reset wins over everything.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StUnlocked;
      cnt_q   <= LastIdx;
      good_q  <= '0;
      asm_q   <= '0;
      dat_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      asm_q   <= asm_d;
      dat_q   <= dat_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Lock FSM next-state: count correctly spaced pulses, drop back on errors.
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    err_d   = 1'b0;
    case (state_q)
      StUnlocked: begin
        if (phase_i) begin
          state_d = StLocking;
          good_d  = '0;
        end
      end
      StLocking: begin
        if (correct) begin
          good_d = good_inc[7:0];
          if (good_inc == 9'(LOCK_COUNT)) begin
            state_d = StLocked;
          end
        end else if (early) begin
          // Realign to the new pulse and start counting again.
          err_d  = 1'b1;
          good_d = '0;
        end else if (missing) begin
          err_d   = 1'b1;
          state_d = StUnlocked;
        end
      end
      StLocked: begin
        if (early) begin
          err_d   = 1'b1;
          state_d = StLocking;
          good_d  = '0;
        end else if (missing) begin
          err_d   = 1'b1;
          state_d = StUnlocked;
        end
      end
      default: begin
        state_d = StUnlocked;
        good_d  = '0;
      end
    endcase
  end

  // Output/datapath: write the beat into its slot, publish complete locked words.
  always_comb begin
    asm_d      = asm_q;
    asm_d[idx] = dat_i;
    fire       = (idx == LastIdx) && (state_q == StLocked) && !err_d;
    dat_d      = fire ? asm_d : dat_q;
    valid_d    = fire;
    locked_o   = (state_q == StLocked);
    valid_o    = valid_q;
    err_o      = err_q;
    dat_o      = dat_q;
  end

`ifdef PHASE_DESER_ERRCNT_EN
  logic [15:0] err_cnt_q;

  // Saturating count of spacing errors, updated together with err_o.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count_o = err_cnt_q;
`else
  assign err_count_o = 16'h0000;
`endif

endmodule

// File: tb/tb_phase_deserializer.sv
// Self-checking bench for phase_deserializer with a behavioural reference model.
module tb_phase_deserializer;

  localparam int unsigned MULT = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned LC   = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_i = 1'b1;
  logic                 phase_i = 1'b0;
  logic [DW-1:0]        dat_i = '0;
  logic [DW*MULT-1:0]   dat_o;
  logic                 valid_o;
  logic                 locked_o;
  logic                 err_o;
  logic [15:0]          err_count_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int since = MULT - 1;

  // Reference model: beat position, lock state (0 unlocked, 1 locking, 2 locked).
  int                 m_st, m_good, m_pos;
  logic [DW-1:0]      m_buf [MULT];
  logic [DW*MULT-1:0] m_dat;
  logic               m_valid, m_locked, m_err;
  logic [15:0]        m_cnt;

  phase_deserializer #(
    .MULT(MULT),
    .DATA_WIDTH(DW),
    .LOCK_COUNT(LC)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .phase_i(phase_i),
    .dat_i(dat_i),
    .dat_o(dat_o),
    .valid_o(valid_o),
    .locked_o(locked_o),
    .err_o(err_o),
    .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_step(input logic rst, input logic ph, input logic [DW-1:0] d);
    logic at_end, err;
    int np;
    if (rst) begin
      m_st = 0; m_good = 0; m_pos = MULT - 1;
      m_dat = '0; m_valid = 0; m_err = 0; m_cnt = '0;
      for (int k = 0; k < MULT; k++) m_buf[k] = '0;
    end else begin
      at_end = (m_pos == MULT - 1);
      err = (m_st != 0) && (ph != at_end);
      np = ph ? 0 : (m_pos + 1) % MULT;
      m_buf[np] = d;
      m_valid = (m_st == 2) && (np == MULT - 1) && !err;
      if (m_valid) for (int k = 0; k < MULT; k++) m_dat[k*DW +: DW] = m_buf[k];
      m_err = err;
`ifdef PHASE_DESER_ERRCNT_EN
      if (err && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`endif
      case (m_st)
        0: if (ph) begin m_st = 1; m_good = 0; end
        1: begin
          if (err) begin m_st = ph ? 1 : 0; m_good = 0; end
          else if (ph) begin
            m_good++;
            if (m_good == LC) m_st = 2;
          end
        end
        default: if (err) begin m_st = ph ? 1 : 0; m_good = 0; end
      endcase
      m_pos = np;
    end
    m_locked = (m_st == 2);
  endtask

  // Drive one fast cycle, advance the model, land 1 time unit after the edge.
  task automatic cycle(input logic rst, input logic ph, input logic [DW-1:0] d);
    rst_i = rst; phase_i = ph; dat_i = d;
    @(posedge clk_i);
    model_step(rst, ph, d);
    cyc++;
    since = rst ? MULT - 1 : (ph ? 0 : since + 1);
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 8'hFF);
    cycle(1'b1, 1'b1, 8'hFF);
    checks++; if (dat_o !== '0) begin errors++; $display("FAIL reset_dat: got %h exp 0", dat_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid_o); end
    checks++; if (locked_o !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b exp 0", locked_o); end
    checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err_o); end
    checks++; if (err_count_o !== 16'h0) begin errors++; $display("FAIL reset_errcnt: got %h exp 0", err_count_o); end
  endtask

  task automatic test_lock();
    int t0, lock_at, first_v, prev_v;
    logic [DW*MULT-1:0] first_word;
    cycle(1'b1, 1'b0, '0);
    t0 = cyc; lock_at = -1; first_v = -1; prev_v = -1; first_word = '0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, (since == MULT - 1), DW'(i));
      checks++;
      if ({dat_o, valid_o, locked_o, err_o} !== {m_dat, m_valid, m_locked, m_err}) begin
        errors++;
        $display("FAIL lock_cycle%0d: got %h/%b%b%b exp %h/%b%b%b", i, dat_o, valid_o, locked_o,
                 err_o, m_dat, m_valid, m_locked, m_err);
      end
      if (locked_o === 1'b1 && lock_at < 0) lock_at = cyc;
      if (valid_o === 1'b1) begin
        if (first_v < 0) begin first_v = cyc; first_word = dat_o; end
        else begin
          checks++;
          if (cyc - prev_v != MULT) begin
            errors++; $display("FAIL lock_spacing: got %0d exp %0d", cyc - prev_v, MULT);
          end
        end
        prev_v = cyc;
      end
    end
    checks++;
    if (lock_at - t0 != LC * MULT + 1) begin
      errors++; $display("FAIL lock_time: got %0d exp %0d", lock_at - t0, LC * MULT + 1);
    end
    checks++;
    if (first_word !== 32'h13121110) begin
      errors++; $display("FAIL lock_first_word: got %h exp 13121110", first_word);
    end
    checks++;
    if (first_v - t0 != 20) begin
      errors++; $display("FAIL lock_first_valid: got %0d exp 20", first_v - t0);
    end
  endtask

  task automatic test_early();
    int e, lock_at, nvalid;
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 30; i++) cycle(1'b0, (since == MULT - 1), DW'($urandom));
    checks++;
    if (locked_o !== 1'b1) begin errors++; $display("FAIL early_prelock: got %b exp 1", locked_o); end
    for (int i = 0; i < 8 && since != 2; i++) cycle(1'b0, 1'b0, DW'($urandom));
    e = cyc;
    cycle(1'b0, 1'b1, DW'($urandom));
    checks++;
    if ({err_o, locked_o, valid_o} !== 3'b100) begin
      errors++; $display("FAIL early_err: got %b exp 100", {err_o, locked_o, valid_o});
    end
    lock_at = -1; nvalid = 0;
    for (int i = 0; i < 24; i++) begin
      cycle(1'b0, (since == MULT - 1), DW'($urandom));
      checks++;
      if ({dat_o, valid_o, locked_o, err_o} !== {m_dat, m_valid, m_locked, m_err}) begin
        errors++;
        $display("FAIL early_cycle%0d: got %h/%b%b%b exp %h/%b%b%b", i, dat_o, valid_o, locked_o,
                 err_o, m_dat, m_valid, m_locked, m_err);
      end
      if (locked_o === 1'b1 && lock_at < 0) lock_at = cyc;
      if (valid_o === 1'b1 && lock_at < 0) nvalid++;
    end
    checks++;
    if (lock_at - e != LC * MULT + 1) begin
      errors++; $display("FAIL early_relock: got %0d exp %0d", lock_at - e, LC * MULT + 1);
    end
    checks++;
    if (nvalid != 0) begin errors++; $display("FAIL early_dropped: got %0d exp 0", nvalid); end
  endtask

  task automatic test_missing();
    int p, lock_at, nvalid;
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 30; i++) cycle(1'b0, (since == MULT - 1), DW'($urandom));
    for (int i = 0; i < 8 && since != MULT - 1; i++) cycle(1'b0, 1'b0, DW'($urandom));
    cycle(1'b0, 1'b0, DW'($urandom));
    checks++;
    if ({err_o, locked_o} !== 2'b10) begin
      errors++; $display("FAIL missing_err: got %b exp 10", {err_o, locked_o});
    end
    nvalid = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, DW'($urandom));
      if (valid_o !== 1'b0 || locked_o !== 1'b0 || err_o !== 1'b0) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin errors++; $display("FAIL missing_quiet: got %0d exp 0", nvalid); end
    p = cyc;
    cycle(1'b0, 1'b1, DW'($urandom));
    lock_at = -1;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, (since == MULT - 1), DW'($urandom));
      if (locked_o === 1'b1 && lock_at < 0) lock_at = cyc;
    end
    checks++;
    if (lock_at - p != LC * MULT + 1) begin
      errors++; $display("FAIL missing_relock: got %0d exp %0d", lock_at - p, LC * MULT + 1);
    end
  endtask

  task automatic test_reset_mid();
    int nvalid;
    cycle(1'b1, 1'b0, '0);
    for (int i = 0; i < 30; i++) cycle(1'b0, (since == MULT - 1), 8'hA0 | DW'(i));
    for (int i = 0; i < 8 && since != 1; i++) cycle(1'b0, (since == MULT - 1), 8'hB5);
    checks++;
    if (dat_o === '0) begin errors++; $display("FAIL rstmid_pre: got %h exp nonzero", dat_o); end
    cycle(1'b1, 1'b0, 8'hC3);
    checks++;
    if ({dat_o, valid_o, locked_o, err_o, err_count_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_zero: got %h/%b%b%b/%h exp 0", dat_o, valid_o, locked_o, err_o,
               err_count_o);
    end
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 8'hC4);
      if (valid_o !== 1'b0) nvalid++;
    end
    checks++;
    if (nvalid != 0) begin errors++; $display("FAIL rstmid_novalid: got %0d exp 0", nvalid); end
  endtask

  task automatic test_idle();
    int bad;
    cycle(1'b1, 1'b0, '0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 1'b0, DW'($urandom));
      if ({valid_o, locked_o, err_o} !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL idle_quiet: got %0d active cycles exp 0", bad); end
  endtask

  task automatic test_random();
    logic ph;
    int nv;
    cycle(1'b1, 1'b0, '0);
    nv = 0;
    for (int i = 0; i < 800; i++) begin
      if (since >= MULT - 1) ph = ($urandom_range(99) < 94);
      else ph = ($urandom_range(99) < 3);
      cycle(1'b0, ph, DW'($urandom));
      checks++;
      if ({dat_o, valid_o, locked_o, err_o, err_count_o} !==
          {m_dat, m_valid, m_locked, m_err, m_cnt}) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h/%b%b%b/%h exp %h/%b%b%b/%h", i, dat_o, valid_o,
                 locked_o, err_o, err_count_o, m_dat, m_valid, m_locked, m_err, m_cnt);
      end
      if (valid_o === 1'b1) nv++;
    end
    checks++;
    if (nv == 0) begin errors++; $display("FAIL random_coverage: got 0 words exp >0"); end
  endtask

  task automatic test_errcnt();
    cycle(1'b1, 1'b0, '0);
`ifdef PHASE_DESER_ERRCNT_EN
    for (int i = 0; i < 70000; i++) cycle(1'b0, 1'b1, DW'(i));
    checks++;
    if (err_count_o !== 16'hFFFF) begin
      errors++; $display("FAIL errcnt_sat: got %h exp ffff", err_count_o);
    end
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, '0);
    checks++;
    if (err_count_o !== 16'hFFFF) begin
      errors++; $display("FAIL errcnt_hold: got %h exp ffff", err_count_o);
    end
    cycle(1'b1, 1'b1, '0);
    checks++;
    if (err_count_o !== 16'h0) begin
      errors++; $display("FAIL errcnt_clear: got %h exp 0", err_count_o);
    end
`else
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, DW'(i));
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL errcnt_err: got %b exp 1", err_o); end
    checks++;
    if (err_count_o !== 16'h0) begin
      errors++; $display("FAIL errcnt_tied: got %h exp 0", err_count_o);
    end
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_lock();
    test_early();
    test_missing();
    test_reset_mid();
    test_idle();
    test_random();
    test_errcnt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
